// File: rtl/kf8255_bus_initiator_if.sv
// Request/response handshake and 8255 CPU-side bus bundled for the bus initiator.
// master = the initiator itself; slave = the fabric plus responder side.
interface kf8255_bus_initiator_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [1:0] req_address;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       chip_select_n;
   logic       read_enable_n;
   logic       write_enable_n;
   logic [1:0] address;
   logic [7:0] data_bus_out;
   logic       data_bus_oe;
   logic [7:0] data_bus_in;

   modport master (
      input  req_valid, req_write, req_address, req_wdata, data_bus_in,
      output req_ready, rsp_valid, rsp_rdata,
      output chip_select_n, read_enable_n, write_enable_n,
      output address, data_bus_out, data_bus_oe
   );

   modport slave (
      output req_valid, req_write, req_address, req_wdata, data_bus_in,
      input  req_ready, rsp_valid, rsp_rdata,
      input  chip_select_n, read_enable_n, write_enable_n,
      input  address, data_bus_out, data_bus_oe
   );
endinterface

// File: rtl/kf8255_bus_initiator.sv
// Turns valid/ready requests into timed 8255 read/write bus cycles with a
// one-cycle response pulse; every bus pin is driven straight from a flop.
module kf8255_bus_initiator #(
   parameter int unsigned SETUP_CYCLES    = 1,
   parameter int unsigned STROBE_CYCLES   = 3,
   parameter int unsigned HOLD_CYCLES     = 1,
   parameter int unsigned RECOVERY_CYCLES = 2
) (
   input  logic                        clock,
   input  logic                        reset_n,
   kf8255_bus_initiator_if.master      bus,
   output logic [2:0]                  o_dbg_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      STROBE  = 3'd2,
      HOLD    = 3'd3,
      RECOVER = 3'd4
   } state_t;

   generate
      if (SETUP_CYCLES < 1 || SETUP_CYCLES > 255 ||
          STROBE_CYCLES < 1 || STROBE_CYCLES > 255 ||
          HOLD_CYCLES < 1 || HOLD_CYCLES > 255 ||
          RECOVERY_CYCLES > 255) begin : g_bad_timing
         $error("kf8255_bus_initiator: timing parameter out of range");
      end
   endgenerate

   // Counter reload values: each state lasts (reload + 1) cycles.
   localparam logic [7:0] L_SETUP   = 8'(SETUP_CYCLES - 1);
   localparam logic [7:0] L_STROBE  = 8'(STROBE_CYCLES - 1);
   localparam logic [7:0] L_HOLD    = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] L_RECOVER = 8'((RECOVERY_CYCLES == 0) ? 0 : RECOVERY_CYCLES - 1);

   state_t     r_state;
   logic [7:0] r_count;
   logic       r_write;
   logic       r_cs_n;
   logic       r_re_n;
   logic       r_we_n;
   logic [1:0] r_address;
   logic [7:0] r_data_out;
   logic       r_oe;
   logic       r_rsp_valid;
   logic [7:0] r_rsp_rdata;

   // Handshake: a request transfers on a rising edge where req_valid and
   // req_ready are both high; req_ready is high only while the FSM is IDLE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_count     <= 8'd0;
         r_write     <= 1'b0;
         r_cs_n      <= 1'b1;
         r_re_n      <= 1'b1;
         r_we_n      <= 1'b1;
         r_address   <= 2'd0;
         r_data_out  <= 8'd0;
         r_oe        <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 8'd0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.req_valid) begin
                  r_write    <= bus.req_write;
                  r_address  <= bus.req_address;
                  r_data_out <= bus.req_wdata;
                  r_oe       <= bus.req_write;
                  r_cs_n     <= 1'b0;
                  r_count    <= L_SETUP;
                  r_state    <= SETUP;
               end
            end
            SETUP: begin
               if (r_count == 8'd0) begin
                  r_count <= L_STROBE;
                  r_state <= STROBE;
                  if (r_write) r_we_n <= 1'b0;
                  else         r_re_n <= 1'b0;
               end else begin
                  r_count <= r_count - 8'd1;
               end
            end
            STROBE: begin
               if (r_count == 8'd0) begin
                  r_we_n  <= 1'b1;
                  r_re_n  <= 1'b1;
                  if (!r_write) r_rsp_rdata <= bus.data_bus_in;
                  r_count <= L_HOLD;
                  r_state <= HOLD;
               end else begin
                  r_count <= r_count - 8'd1;
               end
            end
            HOLD: begin
               if (r_count == 8'd0) begin
                  r_cs_n      <= 1'b1;
                  r_oe        <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_count     <= L_RECOVER;
                  r_state     <= (RECOVERY_CYCLES == 0) ? IDLE : RECOVER;
               end else begin
                  r_count <= r_count - 8'd1;
               end
            end
            RECOVER: begin
               if (r_count == 8'd0) r_state <= IDLE;
               else                 r_count <= r_count - 8'd1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready      = (r_state == IDLE);
   assign bus.rsp_valid      = r_rsp_valid;
   assign bus.rsp_rdata      = r_rsp_rdata;
   assign bus.chip_select_n  = r_cs_n;
   assign bus.read_enable_n  = r_re_n;
   assign bus.write_enable_n = r_we_n;
   assign bus.address        = r_address;
   assign bus.data_bus_out   = r_data_out;
   assign bus.data_bus_oe    = r_oe;
   assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_kf8255_bus_initiator.sv
// Bench for kf8255_bus_initiator: default-timing instance with an 8255-like
// responder model, plus a second instance with S=2 W=1 H=3 R=0.
module tb_kf8255_bus_initiator;

   // ---------------- clock / reset ----------------
   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   kf8255_bus_initiator_if bus ();
   kf8255_bus_initiator_if bus2 ();
   logic [2:0] dbg_state;
   logic [2:0] dbg_state2;

   kf8255_bus_initiator #(
      .SETUP_CYCLES(1), .STROBE_CYCLES(3), .HOLD_CYCLES(1), .RECOVERY_CYCLES(2)
   ) dut (
      .clock(clock), .reset_n(reset_n), .bus(bus.master), .o_dbg_state(dbg_state)
   );

   kf8255_bus_initiator #(
      .SETUP_CYCLES(2), .STROBE_CYCLES(1), .HOLD_CYCLES(3), .RECOVERY_CYCLES(0)
   ) dut2 (
      .clock(clock), .reset_n(reset_n), .bus(bus2.master), .o_dbg_state(dbg_state2)
   );

   // ---------------- counters and scoreboard ----------------
   int         n_cmp = 0;
   int         n_mis = 0;
   logic [7:0] exp_q[$];
   logic [9:0] exp_wr_q[$];
   logic [7:0] obs_rsp_q[$];
   logic [9:0] obs_wr_q[$];
   logic [7:0] exp_rdata = 8'h00;

   // ---------------- responder model ----------------
   logic [7:0] model_regs [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
   logic [7:0] model_ctrl = 8'h00;
   logic       prev_we_n = 1'b1;
   logic       rd_override_en = 1'b0;
   logic [7:0] rd_override = 8'h00;
   int         we_low_cnt = 0;
   int         both_low_cnt = 0;

   always_comb begin
      bus.data_bus_in = rd_override_en ? rd_override : model_regs[bus.address];
   end
   assign bus2.data_bus_in = 8'h00;

   // Write lands on the rising write strobe while chip select is still low.
   always @(negedge clock) begin
      prev_we_n <= bus.write_enable_n;
      if (!bus.chip_select_n && bus.write_enable_n && !prev_we_n) begin
         obs_wr_q.push_back({bus.address, bus.data_bus_out});
         if (bus.address == 2'd3) begin
            if (bus.data_bus_out[7]) begin
               model_ctrl    <= bus.data_bus_out;
               model_regs[0] <= 8'h00;
               model_regs[1] <= 8'h00;
               model_regs[2] <= 8'h00;
            end
         end else begin
            model_regs[bus.address] <= bus.data_bus_out;
         end
      end
      if (bus.rsp_valid) obs_rsp_q.push_back(bus.rsp_rdata);
      if (!bus.write_enable_n) we_low_cnt <= we_low_cnt + 1;
      if (!bus.write_enable_n && !bus.read_enable_n) both_low_cnt <= both_low_cnt + 1;
   end

   // ---------------- per-cycle capture ----------------
   logic       log_cs [1:16];
   logic       log_we [1:16];
   logic       log_re [1:16];
   logic       log_oe [1:16];
   logic       log_rv [1:16];
   logic       log_rdy[1:16];
   logic [1:0] log_ad [1:16];
   logic [7:0] log_do [1:16];
   logic [7:0] log_rd [1:16];

   // Driver: wait for req_ready (bounded), present one request, log ncap cycles.
   task automatic drive_txn(input logic wr, input logic [1:0] a, input logic [7:0] d,
                            input bit push_exp, input int ncap);
      int waited = 0;
      @(negedge clock);
      while (!bus.req_ready && waited < 32) begin
         @(negedge clock);
         waited++;
      end
      n_cmp++;
      if (bus.req_ready !== 1'b1) begin
         n_mis++;
         $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", bus.req_ready, waited);
         return;
      end
      bus.req_valid   = 1'b1;
      bus.req_write   = wr;
      bus.req_address = a;
      bus.req_wdata   = d;
      if (push_exp) begin
         if (wr) exp_wr_q.push_back({a, d});
         exp_q.push_back(exp_rdata);
      end
      @(posedge clock);
      for (int k = 1; k <= ncap; k++) begin
         @(negedge clock);
         log_cs[k]  = bus.chip_select_n;
         log_we[k]  = bus.write_enable_n;
         log_re[k]  = bus.read_enable_n;
         log_oe[k]  = bus.data_bus_oe;
         log_rv[k]  = bus.rsp_valid;
         log_rdy[k] = bus.req_ready;
         log_ad[k]  = bus.address;
         log_do[k]  = bus.data_bus_out;
         log_rd[k]  = bus.rsp_rdata;
         if (k == 1) bus.req_valid = 1'b0;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      repeat (2) @(negedge clock);
      n_cmp++;
      if ({bus.chip_select_n, bus.read_enable_n, bus.write_enable_n} !== 3'b111) begin
         n_mis++;
         $display("FAIL reset_strobes: cs/re/we=%b required 111",
                  {bus.chip_select_n, bus.read_enable_n, bus.write_enable_n});
      end
      n_cmp++;
      if ({bus.address, bus.data_bus_out, bus.data_bus_oe} !== 11'd0) begin
         n_mis++;
         $display("FAIL reset_bus: addr=%h dout=%h oe=%b required 0/00/0",
                  bus.address, bus.data_bus_out, bus.data_bus_oe);
      end
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_rdata} !== 9'd0) begin
         n_mis++;
         $display("FAIL reset_rsp: rsp_valid=%b rsp_rdata=%h required 0/00", bus.rsp_valid, bus.rsp_rdata);
      end
      reset_n = 1'b1;
      @(negedge clock);
      n_cmp++;
      if (bus.req_ready !== 1'b1 || dbg_state !== 3'd0) begin
         n_mis++;
         $display("FAIL reset_ready: req_ready=%b state=%0d required 1/0", bus.req_ready, dbg_state);
      end
      n_cmp++;
      if (bus2.req_ready !== 1'b1 || bus2.chip_select_n !== 1'b1) begin
         n_mis++;
         $display("FAIL reset_ready2: req_ready=%b cs_n=%b required 1/1", bus2.req_ready, bus2.chip_select_n);
      end
   endtask

   task automatic test_write_default;
      logic e_cs, e_we, e_oe, e_rv, e_rdy;
      drive_txn(1'b1, 2'd3, 8'h5A, 1'b1, 8);
      for (int k = 1; k <= 8; k++) begin
         e_cs  = !(k <= 5);
         e_we  = !(k >= 2 && k <= 4);
         e_oe  = (k <= 5);
         e_rv  = (k == 6);
         e_rdy = (k == 8);
         n_cmp++;
         if (log_cs[k] !== e_cs) begin
            n_mis++; $display("FAIL wr_cs_n cyc%0d: got %b required %b", k, log_cs[k], e_cs);
         end
         n_cmp++;
         if (log_we[k] !== e_we || log_re[k] !== 1'b1) begin
            n_mis++; $display("FAIL wr_strobe cyc%0d: we_n=%b re_n=%b required %b/1", k, log_we[k], log_re[k], e_we);
         end
         n_cmp++;
         if (log_oe[k] !== e_oe) begin
            n_mis++; $display("FAIL wr_oe cyc%0d: got %b required %b", k, log_oe[k], e_oe);
         end
         n_cmp++;
         if (log_do[k] !== 8'h5A || log_ad[k] !== 2'd3) begin
            n_mis++; $display("FAIL wr_addr_data cyc%0d: addr=%h dout=%h required 3/5a", k, log_ad[k], log_do[k]);
         end
         n_cmp++;
         if (log_rv[k] !== e_rv || log_rdy[k] !== e_rdy) begin
            n_mis++; $display("FAIL wr_rsp_ready cyc%0d: rsp_valid=%b req_ready=%b required %b/%b",
                              k, log_rv[k], log_rdy[k], e_rv, e_rdy);
         end
      end
   endtask

   task automatic test_read;
      logic e_re;
      rd_override_en = 1'b1;
      rd_override    = 8'hC3;
      exp_rdata      = 8'hC3;
      drive_txn(1'b0, 2'd1, 8'h00, 1'b1, 8);
      rd_override_en = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         e_re = !(k >= 2 && k <= 4);
         n_cmp++;
         if (log_re[k] !== e_re || log_we[k] !== 1'b1 || log_oe[k] !== 1'b0) begin
            n_mis++; $display("FAIL rd_strobe cyc%0d: re_n=%b we_n=%b oe=%b required %b/1/0",
                              k, log_re[k], log_we[k], log_oe[k], e_re);
         end
      end
      n_cmp++;
      if (log_rv[6] !== 1'b1 || log_rd[6] !== 8'hC3) begin
         n_mis++; $display("FAIL rd_data: rsp_valid=%b rsp_rdata=%h required 1/c3", log_rv[6], log_rd[6]);
      end
      drive_txn(1'b1, 2'd2, 8'h77, 1'b1, 8);
      n_cmp++;
      if (log_rv[6] !== 1'b1 || log_rd[8] !== 8'hC3) begin
         n_mis++; $display("FAIL rd_hold_after_write: rsp_valid=%b rsp_rdata=%h required 1/c3", log_rv[6], log_rd[8]);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
      int acc_t [3] = '{0, 0, 0};
      int n_acc = 0;
      int c = 0;
      int we0 = we_low_cnt;
      int both0 = both_low_cnt;
      @(negedge clock);
      bus.req_write   = 1'b1;
      bus.req_address = 2'd0;
      bus.req_wdata   = vals[0];
      bus.req_valid   = 1'b1;
      while (n_acc < 3 && c < 80) begin
         if (bus.req_ready) begin
            acc_t[n_acc] = c;
            exp_wr_q.push_back({2'd0, vals[n_acc]});
            exp_q.push_back(exp_rdata);
            n_acc++;
            @(negedge clock);
            c++;
            if (n_acc < 3) bus.req_wdata = vals[n_acc];
            else           bus.req_valid = 1'b0;
         end else begin
            @(negedge clock);
            c++;
         end
      end
      bus.req_valid = 1'b0;
      n_cmp++;
      if (n_acc != 3) begin
         n_mis++; $display("FAIL b2b_accepts: got %0d acceptances required 3", n_acc);
      end
      for (int i = 1; i < 3; i++) begin
         n_cmp++;
         if (acc_t[i] - acc_t[i-1] != 8) begin
            n_mis++; $display("FAIL b2b_spacing%0d: got %0d cycles required 8", i, acc_t[i] - acc_t[i-1]);
         end
      end
      repeat (10) @(negedge clock);
      n_cmp++;
      if (we_low_cnt - we0 != 9) begin
         n_mis++; $display("FAIL b2b_we_low_cycles: got %0d required 9", we_low_cnt - we0);
      end
      n_cmp++;
      if (both_low_cnt != both0) begin
         n_mis++; $display("FAIL b2b_strobe_overlap: got %0d cycles required 0", both_low_cnt - both0);
      end
   endtask

   task automatic test_params;
      int waited = 0;
      logic e_we, e_cs, e_rv, e_rdy;
      @(negedge clock);
      while (!bus2.req_ready && waited < 32) begin
         @(negedge clock);
         waited++;
      end
      bus2.req_valid   = 1'b1;
      bus2.req_write   = 1'b1;
      bus2.req_address = 2'd2;
      bus2.req_wdata   = 8'h3C;
      @(posedge clock);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         if (k == 1) bus2.req_valid = 1'b0;
         e_we  = !(k == 3);
         e_cs  = !(k <= 6);
         e_rv  = (k == 7);
         e_rdy = (k >= 7);
         n_cmp++;
         if (bus2.write_enable_n !== e_we || bus2.chip_select_n !== e_cs) begin
            n_mis++; $display("FAIL par_strobe cyc%0d: we_n=%b cs_n=%b required %b/%b",
                              k, bus2.write_enable_n, bus2.chip_select_n, e_we, e_cs);
         end
         n_cmp++;
         if (bus2.rsp_valid !== e_rv || bus2.req_ready !== e_rdy) begin
            n_mis++; $display("FAIL par_rsp_ready cyc%0d: rsp_valid=%b req_ready=%b required %b/%b",
                              k, bus2.rsp_valid, bus2.req_ready, e_rv, e_rdy);
         end
      end
   endtask

   task automatic test_reset_mid_write;
      int nw0 = obs_wr_q.size();
      int nr0 = obs_rsp_q.size();
      drive_txn(1'b1, 2'd1, 8'h99, 1'b0, 3);
      n_cmp++;
      if (log_we[3] !== 1'b0) begin
         n_mis++; $display("FAIL rst_mid_in_strobe: we_n=%b required 0", log_we[3]);
      end
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.chip_select_n !== 1'b1 || bus.write_enable_n !== 1'b1 || bus.data_bus_oe !== 1'b0) begin
         n_mis++; $display("FAIL rst_mid_outputs: cs_n=%b we_n=%b oe=%b required 1/1/0",
                           bus.chip_select_n, bus.write_enable_n, bus.data_bus_oe);
      end
      n_cmp++;
      if (dbg_state !== 3'd0 || bus.address !== 2'd0 || bus.data_bus_out !== 8'h00) begin
         n_mis++; $display("FAIL rst_mid_state: state=%0d addr=%h dout=%h required 0/0/00",
                           dbg_state, bus.address, bus.data_bus_out);
      end
      @(negedge clock);
      reset_n   = 1'b1;
      exp_rdata = 8'h00;
      repeat (8) @(negedge clock);
      n_cmp++;
      if (obs_rsp_q.size() != nr0 || obs_wr_q.size() != nw0) begin
         n_mis++; $display("FAIL rst_mid_dropped: new rsp=%0d new writes=%0d required 0/0",
                           obs_rsp_q.size() - nr0, obs_wr_q.size() - nw0);
      end
      n_cmp++;
      if (bus.rsp_rdata !== 8'h00) begin
         n_mis++; $display("FAIL rst_mid_rdata: got %h required 00", bus.rsp_rdata);
      end
   endtask

   task automatic test_kf8255;
      drive_txn(1'b1, 2'd3, 8'h80, 1'b1, 8);
      drive_txn(1'b1, 2'd0, 8'hA5, 1'b1, 8);
      exp_rdata = 8'hA5;
      drive_txn(1'b0, 2'd0, 8'h00, 1'b1, 8);
      n_cmp++;
      if (model_ctrl !== 8'h80) begin
         n_mis++; $display("FAIL kf_ctrl: responder control=%h required 80", model_ctrl);
      end
      n_cmp++;
      if (log_rv[6] !== 1'b1 || log_rd[6] !== 8'hA5) begin
         n_mis++; $display("FAIL kf_read_porta: rsp_valid=%b rsp_rdata=%h required 1/a5", log_rv[6], log_rd[6]);
      end
   endtask

   task automatic test_scoreboard;
      int nr;
      int nw;
      repeat (4) @(negedge clock);
      n_cmp++;
      if (obs_rsp_q.size() != exp_q.size()) begin
         n_mis++; $display("FAIL sb_rsp_count: got %0d required %0d", obs_rsp_q.size(), exp_q.size());
      end
      nr = (obs_rsp_q.size() < exp_q.size()) ? obs_rsp_q.size() : exp_q.size();
      for (int i = 0; i < nr; i++) begin
         n_cmp++;
         if (obs_rsp_q[i] !== exp_q[i]) begin
            n_mis++; $display("FAIL sb_rsp%0d: rsp_rdata=%h required %h", i, obs_rsp_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (obs_wr_q.size() != exp_wr_q.size()) begin
         n_mis++; $display("FAIL sb_wr_count: got %0d required %0d", obs_wr_q.size(), exp_wr_q.size());
      end
      nw = (obs_wr_q.size() < exp_wr_q.size()) ? obs_wr_q.size() : exp_wr_q.size();
      for (int i = 0; i < nw; i++) begin
         n_cmp++;
         if (obs_wr_q[i] !== exp_wr_q[i]) begin
            n_mis++; $display("FAIL sb_wr%0d: addr/data=%h required %h", i, obs_wr_q[i], exp_wr_q[i]);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_address  = 2'd0;
      bus.req_wdata    = 8'h00;
      bus2.req_valid   = 1'b0;
      bus2.req_write   = 1'b0;
      bus2.req_address = 2'd0;
      bus2.req_wdata   = 8'h00;
      test_reset();
      test_write_default();
      test_read();
      test_back_to_back();
      test_params();
      test_reset_mid_write();
      test_kf8255();
      test_scoreboard();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/kf8255_bus_initiator.md
# kf8255_bus_initiator

Bus-cycle generator that drives the CPU side of a KF8255 peripheral interface: chip select, read/write strobes, 2-bit address and 8-bit data. It converts a valid/ready request interface from the system fabric into timed, glitch-free 8255 read and write cycles. It returns a one-cycle response pulse carrying read data. It sits between the internal bus fabric and any KF8255 instance, or an equivalent 8255-protocol responder.

## Interface
- SETUP_CYCLES, 1: cycles with chip select low and address/data stable before the strobe falls; legal range 1..255.
- STROBE_CYCLES, 3: strobe-low width in cycles; legal range 1..255.
- HOLD_CYCLES, 1: cycles after the strobe rises with chip select, address and data still held; legal range 1..255.
- RECOVERY_CYCLES, 2: cycles with chip select high before the next request is accepted; legal range 0..255.
- clock  in  1  single system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept a request.
- req_write  in  1  1 = write cycle, 0 = read cycle.
- req_address  in  2  target register address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle pulse marking transaction completion, for both reads and writes.
- rsp_rdata  out  8  captured read data; holds its value until the next read completes.
- chip_select_n  out  1  active-low chip select.
- read_enable_n  out  1  active-low read strobe.
- write_enable_n  out  1  active-low write strobe.
- address  out  2  peripheral address.
- data_bus_out  out  8  write data driven to the peripheral.
- data_bus_oe  out  1  output enable for data_bus_out; high for the entire chip-select window of a write only.
- data_bus_in  in  8  read data returned by the peripheral.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER. A single 8-bit down-counter times each state.
- IDLE:
  - req_ready = 1; this is the only state where it is 1. It decodes directly from the state.
  - On req_valid & req_ready: latch write/address/wdata, then go to SETUP.
- SETUP: chip_select_n = 0; address and data_bus_out driven from the latched values; data_bus_oe = latched write; both strobes high. Lasts SETUP_CYCLES, then STROBE.
- STROBE: write_enable_n = 0 for a write, or read_enable_n = 0 for a read; the other strobe stays high. Lasts STROBE_CYCLES, then HOLD.
- HOLD: both strobes high; chip select, address, data and oe unchanged. Lasts HOLD_CYCLES.
  - Then RECOVER, or IDLE if RECOVERY_CYCLES = 0.
  - HOLD ≥ 1 is mandatory: the responder detects the write on the rising write strobe while chip select is low, and registers the address one cycle late.
- RECOVER: chip_select_n = 1; oe = 0; address and data_bus_out keep their last values. Lasts RECOVERY_CYCLES, then IDLE.
- Read capture: data_bus_in is sampled into rsp_rdata on the clock edge that ends the final STROBE cycle. Writes never modify rsp_rdata.
- req_valid outside IDLE is ignored; the request is not accepted until req_ready is high.
- read_enable_n and write_enable_n are never low in the same cycle.
- All bus outputs come directly from flops; no combinational path from req_* to bus pins.
- Illegal parameter values (SETUP/STROBE/HOLD < 1, or any value > 255) abort elaboration.

## Timing
- Reset values (asynchronous, immediate on reset_n low):
  - chip_select_n = 1, read_enable_n = 1, write_enable_n = 1.
  - address = 0, data_bus_out = 0, data_bus_oe = 0.
  - rsp_valid = 0, rsp_rdata = 0.
  - State = IDLE, so req_ready = 1 once reset_n is high.
- Notation: a request is accepted at edge T0; S = SETUP_CYCLES, W = STROBE_CYCLES, H = HOLD_CYCLES, R = RECOVERY_CYCLES.
- Cycle schedule after acceptance:
  - chip_select_n low in cycles T0+1 .. T0+S+W+H.
  - Strobe low in cycles T0+S+1 .. T0+S+W.
  - rsp_valid high only in cycle T0+S+W+H+1.
  - req_ready high again from cycle T0+S+W+H+R+1.
- Back-to-back throughput is one transaction per S+W+H+R+1 cycles; 8 cycles with defaults.
- Reset asserted mid-transaction: the transaction is dropped, no rsp_valid is issued, and outputs go to their reset values in the same cycle with no trailing strobe edge.

## Test plan
- Reset release, then write addr=3 data=0x5A with defaults:
  - chip_select_n low in cycles 1-5 after acceptance; write_enable_n low in cycles 2-4.
  - data_bus_oe=1 and data_bus_out=0x5A throughout cycles 1-5.
  - rsp_valid pulses in cycle 6; req_ready returns in cycle 8.
- Read addr=1 with the model driving data_bus_in=0xC3 during the strobe:
  - read_enable_n low in cycles 2-4; data_bus_oe stays 0.
  - rsp_valid in cycle 6 with rsp_rdata=0xC3; rsp_rdata is still 0xC3 after a following write.
- req_valid held high for 3 back-to-back writes (0x11, 0x22, 0x33) → acceptances exactly 8 cycles apart; the strobes of the 3 writes never overlap; the responder model sees 0x11, 0x22, 0x33 in order.
- Parameters S=2, W=1, H=3, R=0 → write_enable_n low for exactly 1 cycle (cycle 3); rsp_valid in cycle 7; req_ready high in cycle 7.
- reset_n pulsed low during STROBE of a write → chip_select_n and write_enable_n go high immediately; no rsp_valid; the responder model records no write.
- KF8255 instance connected as responder; write control word 0x80, then port A 0xA5, then read port A → rsp_rdata = 0xA5.
